// File: rtl/alu_share_arb.sv
// Purpose : round-robin share of one combinational R-type ALU between NUM_REQ requesters.
// Latency : 1 cycle from accept (req_valid & req_ready) to rsp_valid; one op per cycle sustained.
// Backpr. : a held response with rsp_ready low blocks every grant; drain and new accept may coincide.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_valid/req_ready [NUM_REQ]     per-requester handshake (req_ready one-hot or zero, combinational)
//   req_opcode/funct3/funct7/in1/in2  packed per-requester fields, requester i in slice i
//   alu_opcode/funct3/funct7/in1/in2  fields of the granted requester (or last_grant when idle)
//   alu_out                           combinational result returned by the shared ALU
//   rsp_valid/rsp_ready               response handshake
//   rsp_id/rsp_data/rsp_err           requester index, registered result (0 on error), illegal-op flag
//
// Optional build macro ALU_SHARE_ARB_STATS_EN adds saturating counters:
//   grant_cnt (16 bits per requester), stall_cnt, err_cnt.
// ID_W must satisfy 2**ID_W >= NUM_REQ.

module alu_share_arb #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [7*NUM_REQ-1:0]  req_opcode,
  input  logic [3*NUM_REQ-1:0]  req_funct3,
  input  logic [7*NUM_REQ-1:0]  req_funct7,
  input  logic [32*NUM_REQ-1:0] req_in1,
  input  logic [32*NUM_REQ-1:0] req_in2,
  output logic [6:0]            alu_opcode,
  output logic [2:0]            alu_funct3,
  output logic [6:0]            alu_funct7,
  output logic [31:0]           alu_in1,
  output logic [31:0]           alu_in2,
  input  logic [31:0]           alu_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err
`ifdef ALU_SHARE_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0] grant_cnt,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           err_cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     dat;
    logic            err;
  } rsp_t;

  state_t              state_q;
  state_t              state_d;
  rsp_t                rsp_q;
  logic [ID_W-1:0]     last_grant_q;

  logic                can_accept;
  logic                accept;
  logic                hit;
  int                  hit_off;
  int                  gnt_sum;
  logic [ID_W-1:0]     start_idx;
  logic [ID_W-1:0]     gnt_idx;
  logic [ID_W-1:0]     sel_idx;
  logic [2*NUM_REQ-1:0] dbl_valid;
  logic [NUM_REQ-1:0]  rot_valid;
  logic                op_legal;

  // Legal RV32I R-type encodings: OP opcode with the ten defined {funct7,funct3} pairs.
  function automatic logic is_legal(input logic [6:0] opc, input logic [2:0] f3,
                                    input logic [6:0] f7);
    logic [9:0] key;
    key      = {f7, f3};
    is_legal = 1'b0;
    if (opc == 7'b0110011) begin
      case (key)
        10'b0000000_000, 10'b0100000_000, 10'b0000000_001, 10'b0000000_010,
        10'b0000000_011, 10'b0000000_100, 10'b0000000_101, 10'b0100000_101,
        10'b0000000_110, 10'b0000000_111: is_legal = 1'b1;
        default:                          is_legal = 1'b0;
      endcase
    end
  endfunction

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (accept) state_d = FULL;
               else if (rsp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    rsp_valid  = (state_q == FULL);
    can_accept = (state_q == EMPTY) | rsp_ready;
  end

  // ---------------------------------------------------------------------------
  // Round-robin search. Rotating a doubled copy of req_valid puts the
  // requester after last_grant at bit 0, so the first set bit is the winner.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (last_grant_q == ID_W'(NUM_REQ - 1)) start_idx = '0;
    else                                    start_idx = last_grant_q + 1'b1;
  end

  assign dbl_valid = {req_valid, req_valid};
  assign rot_valid = NUM_REQ'(dbl_valid >> start_idx);

  always_comb begin
    hit     = 1'b0;
    hit_off = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit && rot_valid[i]) begin
        hit     = 1'b1;
        hit_off = i;
      end
    end
    gnt_sum = int'(start_idx) + hit_off;
    if (gnt_sum >= NUM_REQ) gnt_sum = gnt_sum - NUM_REQ;
    gnt_idx = ID_W'(gnt_sum);
  end

  assign accept = can_accept & hit;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (gnt_idx == ID_W'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // ALU operand mux. When idle the last granted requester stays selected so
  // the ALU inputs are always driven from a real requester.
  // ---------------------------------------------------------------------------
  assign sel_idx = accept ? gnt_idx : last_grant_q;

  always_comb begin
    alu_opcode = '0;
    alu_funct3 = '0;
    alu_funct7 = '0;
    alu_in1    = '0;
    alu_in2    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == ID_W'(i)) begin
        alu_opcode = req_opcode[7*i +: 7];
        alu_funct3 = req_funct3[3*i +: 3];
        alu_funct7 = req_funct7[7*i +: 7];
        alu_in1    = req_in1[32*i +: 32];
        alu_in2    = req_in2[32*i +: 32];
      end
    end
  end

  assign op_legal = is_legal(alu_opcode, alu_funct3, alu_funct7);

  // ---------------------------------------------------------------------------
  // Response register. An illegal op loads 0 so an undefined ALU result is
  // never captured.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q        <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      rsp_q.id     <= gnt_idx;
      rsp_q.dat    <= op_legal ? alu_out : 32'd0;
      rsp_q.err    <= ~op_legal;
      last_grant_q <= gnt_idx;
    end
  end

  assign rsp_id   = rsp_q.id;
  assign rsp_data = rsp_q.dat;
  assign rsp_err  = rsp_q.err;

`ifdef ALU_SHARE_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics counters.
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0][15:0] gcnt_q;
  logic [15:0]              stall_q;
  logic [15:0]              err_q;
  logic                     stall;

  assign stall = (|req_valid) & ~(|req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt_q  <= '0;
      stall_q <= '0;
      err_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && (gcnt_q[i] != 16'hFFFF)) gcnt_q[i] <= gcnt_q[i] + 16'd1;
      end
      if (stall && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (accept && !op_legal && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
    end
  end

  assign grant_cnt = gcnt_q;
  assign stall_cnt = stall_q;
  assign err_cnt   = err_q;
`endif

endmodule
